uart_tx_frame: RTL and testbench

Parametrised UART transmitter: the successor to the fixed 8N1 transmitter.
- Adds configurable data width, parity mode and stop-bit count.
- Adds a valid/ready input handshake, plus busy and frame-done status.
- Sits between a byte producer (FIFO or command sequencer) and the FPGA TX pin; one frame in flight at a time.

---
 rtl/uart_tx_frame.sv | 128 ++++++++++++
 tb/tb_uart_tx_frame.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmitter with configurable width, parity and stop bits.
// Accepts one payload per valid/ready handshake; one frame in flight.
module uart_tx_frame #(
    parameter int F         = 50000000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int DIV = F / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_DONE  = CW'(DIV - 2);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY == 1);

    if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
        $error("uart_tx_frame: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t               state;
    logic [CW-1:0]        baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_q;
    logic                 wrap;

    assign wrap  = (baud_cnt == CNT_LAST);
    assign ready = (state == S_IDLE) & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            shreg    <= '0;
            par_q    <= 1'b0;
        end else begin
            // wraps to zero on the same edge that changes state
            baud_cnt <= wrap ? '0 : baud_cnt + 1'b1;
            unique case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (valid) begin
                        shreg <= data;
                        par_q <= (^data) ^ ODD;
                        state <= S_START;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (wrap) begin
                        state <= S_DATA;
                        tx    <= shreg[0];
                    end
                end
                S_DATA: begin
                    if (wrap) begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                state <= S_PAR;
                                tx    <= par_q;
                            end else begin
                                state <= S_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end
                end
                S_PAR: begin
                    if (wrap) begin
                        state <= S_STOP;
                        tx    <= 1'b1;
                    end
                end
                S_STOP: begin
                    // raise done for the last clock of the last stop bit
                    if (bit_cnt == STOP_LAST && baud_cnt == CNT_DONE)
                        done <= 1'b1;
                    if (wrap) begin
                        if (bit_cnt == STOP_LAST) begin
                            state   <= S_IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b0;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations on one clock, per-cycle
// scoreboard of {tx, busy, done, ready} against a bit-level frame model.
module tb_uart_tx_frame;

    localparam int F    = 8000000;
    localparam int BAUD = 1000000;
    localparam int DIV  = 8;

    typedef struct packed {
        logic tx;
        logic busy;
        logic done;
        logic ready;
    } obs_t;

    logic       clk;
    logic       rst;
    logic [3:0] valid_v;
    logic [3:0] ready_v;
    logic [3:0] tx_v;
    logic [3:0] busy_v;
    logic [3:0] done_v;
    logic [7:0] data0;
    logic [7:0] data1;
    logic [7:0] data2;
    logic [6:0] data3;

    obs_t exp_q[$];
    int   total;
    int   bad;

    uart_tx_frame #(.F(F), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .data(data0), .valid(valid_v[0]),
        .ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    uart_tx_frame #(.F(F), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .data(data1), .valid(valid_v[1]),
        .ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    uart_tx_frame #(.F(F), .BAUD(BAUD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .data(data2), .valid(valid_v[2]),
        .ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2])
    );

    uart_tx_frame #(.F(F), .BAUD(BAUD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
        .clk(clk), .rst(rst), .data(data3), .valid(valid_v[3]),
        .ready(ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push_n(int n, logic t, logic b, logic dn, logic r);
        for (int i = 0; i < n; i++)
            exp_q.push_back(obs_t'({t, b, dn, r}));
    endfunction

    function automatic logic par_bit(logic [8:0] d, int nbits, int mode);
        logic p;
        p = 1'b0;
        for (int i = 0; i < nbits; i++)
            p = p ^ d[i];
        return (mode == 1) ? ~p : p;
    endfunction

    function automatic void push_frame(logic [8:0] d, int nbits, int mode, int stops);
        push_n(DIV, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++)
            push_n(DIV, d[i], 1'b1, 1'b0, 1'b0);
        if (mode != 0)
            push_n(DIV, par_bit(d, nbits, mode), 1'b1, 1'b0, 1'b0);
        push_n(stops * DIV - 1, 1'b1, 1'b1, 1'b0, 1'b0);
        push_n(1, 1'b1, 1'b1, 1'b1, 1'b0);
    endfunction

    function automatic void push_idle(int n);
        push_n(n, 1'b1, 1'b0, 1'b0, 1'b1);
    endfunction

    task automatic drive(int idx, logic v, logic [7:0] d);
        valid_v[idx] = v;
        case (idx)
            0: data0 = d;
            1: data1 = d;
            2: data2 = d;
            default: data3 = d[6:0];
        endcase
    endtask

    task automatic cmp(int idx, string tag);
        obs_t o;
        obs_t e;
        o = {tx_v[idx], busy_v[idx], done_v[idx], ready_v[idx]};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s: observed=%b expected=<queue empty>", tag, o);
        end else begin
            e = exp_q.pop_front();
            assert (o === e) else begin
                bad++;
                $error("FAIL %s: dut%0d observed tx/busy/done/ready=%b expected=%b",
                       tag, idx, o, e);
            end
        end
    endtask

    task automatic check(int idx, int n, string tag);
        repeat (n) begin
            @(posedge clk);
            #1;
            cmp(idx, tag);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        valid_v = '0;
        data0   = '0;
        data1   = '0;
        data2   = '0;
        data3   = '0;

        // reset state on every configuration
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            push_n(1, 1'b1, 1'b0, 1'b0, 1'b0);
            cmp(i, "reset");
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            push_idle(1);
            cmp(i, "post_reset_idle");
        end

        // 8N1 0xAA, single-clock valid
        @(negedge clk);
        drive(0, 1'b1, 8'hAA);
        push_frame(9'h0AA, 8, 0, 1);
        push_idle(3);
        check(0, 1, "t1_first");
        drive(0, 1'b0, 8'h55);
        check(0, 82, "t1_8n1_aa");

        // even and odd parity on 0x07
        @(negedge clk);
        drive(1, 1'b1, 8'h07);
        push_frame(9'h007, 8, 2, 1);
        push_idle(2);
        check(1, 1, "t2_even_first");
        drive(1, 1'b0, 8'h00);
        check(1, 89, "t2_8e1_07");

        @(negedge clk);
        drive(2, 1'b1, 8'h07);
        push_frame(9'h007, 8, 1, 1);
        push_idle(2);
        check(2, 1, "t2_odd_first");
        drive(2, 1'b0, 8'h00);
        check(2, 89, "t2_8o1_07");

        // 7 bits, odd parity, two stop bits
        @(negedge clk);
        drive(3, 1'b1, 8'h55);
        push_frame(9'h055, 7, 1, 2);
        push_idle(2);
        check(3, 1, "t3_first");
        drive(3, 1'b0, 8'h2A);
        check(3, 89, "t3_7o2_55");

        // back-to-back with valid held, data changed mid-frame
        @(negedge clk);
        drive(0, 1'b1, 8'h01);
        push_frame(9'h001, 8, 0, 1);
        push_idle(1);
        push_frame(9'h080, 8, 0, 1);
        push_idle(2);
        check(0, 1, "t4_first");
        drive(0, 1'b1, 8'h80);
        check(0, 79, "t4_frame1");
        check(0, 1, "t4_gap");
        check(0, 1, "t4_frame2_first");
        drive(0, 1'b0, 8'hFF);
        check(0, 81, "t4_frame2");

        // reset during the 4th data bit of 0x3C
        @(negedge clk);
        drive(0, 1'b1, 8'h3C);
        push_frame(9'h03C, 8, 0, 1);
        check(0, 1, "t5_first");
        drive(0, 1'b0, 8'h00);
        check(0, 33, "t5_partial");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        push_n(1, 1'b1, 1'b0, 1'b0, 1'b0);
        check(0, 1, "t5_in_reset");
        @(negedge clk);
        rst = 1'b0;
        push_idle(4);
        check(0, 4, "t5_released");
        @(negedge clk);
        drive(0, 1'b1, 8'hC3);
        push_frame(9'h0C3, 8, 0, 1);
        push_idle(2);
        check(0, 1, "t5_c3_first");
        drive(0, 1'b0, 8'h00);
        check(0, 81, "t5_c3");

        // valid while busy is ignored
        @(negedge clk);
        drive(0, 1'b1, 8'h12);
        push_frame(9'h012, 8, 0, 1);
        push_idle(12);
        check(0, 1, "t6_first");
        drive(0, 1'b0, 8'h00);
        check(0, 19, "t6_pre");
        @(negedge clk);
        drive(0, 1'b1, 8'hFF);
        check(0, 1, "t6_poke");
        drive(0, 1'b0, 8'h00);
        check(0, 71, "t6_ignored");

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL leftover: observed=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
